// File: rtl/hc_seq_if.sv
// hc_seq_if: command/strobe bundle between the HC-128 host wrapper and hc_seq_ctrl.
//   master (host/datapath side): drives init, next; observes every status and strobe.
//   slave  (controller side)   : observes init, next; drives ready, keyed, s_valid,
//                                exp_we, exp_idx, rd_en, update_state, update_s,
//                                init_mode, step.
interface hc_seq_if;
   logic        init, next;
   logic        ready, keyed, s_valid;
   logic        exp_we, rd_en, update_state, update_s, init_mode;
   logic [10:0] exp_idx;
   logic [9:0]  step;
   modport master (
      output init, next,
      input  ready, keyed, s_valid, exp_we, exp_idx, rd_en, update_state, update_s, init_mode, step
   );
   modport slave (
      input  init, next,
      output ready, keyed, s_valid, exp_we, exp_idx, rd_en, update_state, update_s, init_mode, step
   );
endinterface

// File: rtl/hc_seq_ctrl.sv
// hc_seq_ctrl: sequencing controller for the HC-128 keystream datapath.
//   Owns the step counter and issues W expansion, init-mixing and keystream strobes.
//   Ports: clk (rising edge), reset_n (synchronous, active-low),
//          bus (hc_seq_if.slave): init/next commands in; ready, keyed, s_valid,
//          exp_we/exp_idx, rd_en, update_state, update_s, init_mode, step out.
//   Optional build macro HC_CTRL_STREAM_EN: a held next streams one word per 2 cycles.
module hc_seq_ctrl #(
   parameter int EXP_WORDS = 1280,
   parameter int MIX_STEPS = 1024
) (
   input logic     clk,
   input logic     reset_n,
   hc_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, EXPAND, MIX_RD, MIX_WR, READY, GEN_RD, GEN_WR} state_t;
   localparam logic [10:0] EXP_LAST = 11'(EXP_WORDS - 1);
   localparam logic [9:0]  MIX_LAST = 10'(MIX_STEPS - 1);
   state_t      state, state_nx;
   logic [10:0] exp_idx;
   logic [9:0]  step;
   logic        keyed, s_valid, start;
   // init is only honoured in the two idle states; elsewhere it is dropped, not queued
   assign start = (state == IDLE || state == READY) && bus.init;
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = bus.init ? EXPAND : IDLE;
         EXPAND:  state_nx = (exp_idx == EXP_LAST) ? MIX_RD : EXPAND;
         MIX_RD:  state_nx = MIX_WR;
         MIX_WR:  state_nx = (step == MIX_LAST) ? READY : MIX_RD;
         READY:   state_nx = bus.init ? EXPAND : bus.next ? GEN_RD : READY;
         GEN_RD:  state_nx = GEN_WR;
`ifdef HC_CTRL_STREAM_EN
         GEN_WR:  state_nx = bus.next ? GEN_RD : READY;
`else
         GEN_WR:  state_nx = READY;
`endif
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         exp_idx <= '0;
         step    <= '0;
         keyed   <= 1'b0;
         s_valid <= 1'b0;
      end else begin
         s_valid <= state == GEN_WR;
         if (start) begin
            exp_idx <= '0;
            step    <= '0;
            keyed   <= 1'b0;
         end else begin
            // exp_idx holds at the last word until the next init reloads it
            if (state == EXPAND) exp_idx <= exp_idx + 11'(exp_idx != EXP_LAST);
            if (state == MIX_WR) step <= (step == MIX_LAST) ? '0 : step + 10'd1;
            if (state == GEN_WR) step <= step + 10'd1;
            if (state == MIX_WR && step == MIX_LAST) keyed <= 1'b1;
         end
      end
   end
   assign bus.ready        = state == IDLE || state == READY;
   assign bus.keyed        = keyed;
   assign bus.s_valid      = s_valid;
   assign bus.exp_we       = state == EXPAND;
   assign bus.exp_idx      = exp_idx;
   assign bus.rd_en        = state == MIX_RD || state == GEN_RD;
   assign bus.update_state = state == MIX_WR || state == GEN_WR;
   assign bus.update_s     = state == GEN_WR;
   assign bus.init_mode    = state == MIX_WR;
   assign bus.step         = step;
endmodule

// File: tb/tb_hc_seq_ctrl.sv
// tb_hc_seq_ctrl: directed, table-driven self-checking bench for hc_seq_ctrl.
module tb_hc_seq_ctrl;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;
   hc_seq_if bus();
   hc_seq_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic       i, n, rdy, rd, upd, us, sv;
      logic [9:0] st;
   } vec_t;
   vec_t vt [9];
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask
   initial begin
      int ne, nr, nu, bad_idx, bad_mode, excl, rise, bad, nsv, nrdy, found;
      vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0};
      vt[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd1};
      vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd1};
      vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd1};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd2};
      vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd2};
      vt[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd2};
      vt[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'd3};
      reset_n = 1'b0; bus.init = 1'b0; bus.next = 1'b0;
      tick; tick;
      chk("rst_ready", int'(bus.ready), 1);
      chk("rst_keyed", int'(bus.keyed), 0);
      chk("rst_step", int'(bus.step), 0);
      chk("rst_exp_idx", int'(bus.exp_idx), 0);
      chk("rst_strobes", int'({bus.exp_we, bus.rd_en, bus.update_state, bus.update_s, bus.init_mode, bus.s_valid}), 0);
      reset_n = 1'b1;
      // next without a key is ignored
      bus.next = 1'b1; bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (bus.rd_en || bus.update_s || !bus.ready || bus.keyed || bus.step != 0) bad++;
      end
      bus.next = 1'b0;
      chk("idle_next_ignored", bad, 0);
      // full key setup
      bus.init = 1'b1; tick; bus.init = 1'b0;
      ne = 0; nr = 0; nu = 0; bad_idx = 0; bad_mode = 0; excl = 0; rise = 0;
      for (int c = 1; c <= 4000; c++) begin
         if (bus.ready) begin rise = c; break; end
         if (bus.exp_we) begin
            if (int'(bus.exp_idx) != ne) bad_idx++;
            ne++;
         end
         if (bus.rd_en) nr++;
         if (bus.update_state) begin
            nu++;
            if (!bus.init_mode) bad_mode++;
         end
         if (int'(bus.exp_we) + int'(bus.rd_en) + int'(bus.update_state) > 1) excl++;
         tick;
      end
      chk("exp_we_cycles", ne, 1280);
      chk("exp_idx_seq_errs", bad_idx, 0);
      chk("mix_rd_pulses", nr, 1024);
      chk("mix_wr_pulses", nu, 1024);
      chk("mix_init_mode_errs", bad_mode, 0);
      chk("strobe_exclusive_errs", excl, 0);
      chk("ready_rise_cycle", rise, 3329);
      chk("keyed_after_setup", int'(bus.keyed), 1);
      chk("step_after_setup", int'(bus.step), 0);
      // three single keystream requests
      for (int k = 0; k < 9; k++) begin
         bus.init = vt[k].i; bus.next = vt[k].n;
         tick;
         chk($sformatf("v%0d_ready", k), int'(bus.ready), int'(vt[k].rdy));
         chk($sformatf("v%0d_rd_en", k), int'(bus.rd_en), int'(vt[k].rd));
         chk($sformatf("v%0d_update_state", k), int'(bus.update_state), int'(vt[k].upd));
         chk($sformatf("v%0d_update_s", k), int'(bus.update_s), int'(vt[k].us));
         chk($sformatf("v%0d_s_valid", k), int'(bus.s_valid), int'(vt[k].sv));
         chk($sformatf("v%0d_step", k), int'(bus.step), int'(vt[k].st));
      end
      bus.next = 1'b0;
      // bring step back to 0, then 1024 checked words
      for (int w = 0; w < 1021; w++) begin
         bus.next = 1'b1; tick; bus.next = 1'b0; tick; tick;
      end
      chk("step_realigned", int'(bus.step), 0);
      bad = 0; nsv = 0;
      for (int w = 0; w < 1024; w++) begin
         bus.next = 1'b1; tick; bus.next = 1'b0; tick;
         if (!bus.update_s || bus.step[9] != (w >= 512)) bad++;
         tick;
         if (bus.s_valid) nsv++;
      end
      chk("pq_select_errs", bad, 0);
      chk("word_count", nsv, 1024);
      chk("step_wrap", int'(bus.step), 0);
      // init and next together: init wins
      bus.init = 1'b1; bus.next = 1'b1; tick; bus.init = 1'b0; bus.next = 1'b0;
      chk("initnext_exp_we", int'(bus.exp_we), 1);
      chk("initnext_rd_en", int'(bus.rd_en), 0);
      chk("initnext_ready", int'(bus.ready), 0);
      chk("initnext_keyed", int'(bus.keyed), 0);
      nsv = 0;
      for (int c = 0; c < 3; c++) begin tick; if (bus.s_valid) nsv++; end
      chk("initnext_no_s_valid", nsv, 0);
      // reset in the middle of mixing
      found = 0;
      for (int c = 0; c < 4000; c++) begin
         if (bus.rd_en && bus.step == 10'd300) begin found = 1; break; end
         tick;
      end
      chk("mix_step300_reached", found, 1);
      reset_n = 1'b0; tick;
      chk("midrst_ready", int'(bus.ready), 1);
      chk("midrst_keyed", int'(bus.keyed), 0);
      chk("midrst_step", int'(bus.step), 0);
      chk("midrst_strobes", int'({bus.exp_we, bus.rd_en, bus.update_state, bus.update_s, bus.s_valid}), 0);
      reset_n = 1'b1;
      // re-key, then hold next
      bus.init = 1'b1; tick; bus.init = 1'b0;
      found = 0;
      for (int c = 0; c < 4000; c++) begin
         if (bus.ready) begin found = 1; break; end
         tick;
      end
      chk("rekey_ready", found, 1);
      bus.next = 1'b1; bad = 0; nsv = 0; nrdy = 0;
      for (int k = 1; k <= 22; k++) begin
         tick;
         if (k == 20) bus.next = 1'b0;
`ifdef HC_CTRL_STREAM_EN
         if (bus.s_valid != (k >= 3 && k <= 21 && k % 2 == 1)) bad++;
`else
         if (bus.s_valid != (k <= 21 && k % 3 == 0)) bad++;
`endif
         if (bus.s_valid) nsv++;
         if (k <= 20 && bus.ready) nrdy++;
      end
`ifdef HC_CTRL_STREAM_EN
      chk("stream_words", nsv, 10);
      chk("stream_ready_highs", nrdy, 0);
`else
      chk("held_next_words", nsv, 7);
      chk("held_next_ready_highs", nrdy, 6);
`endif
      chk("held_next_pattern_errs", bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hc_seq_ctrl.md
# hc_seq_ctrl

Sequencing controller for the HC-128 keystream datapath. It owns the step counter and issues every strobe the P/Q table datapath needs:
- key/IV expansion into the W array;
- 1024 initialisation mixing steps;
- two-cycle read/write keystream steps, with an init/next command handshake towards the host wrapper.

It sits between the host register interface and the cipher core.

## Interface
Parameters:
- EXP_WORDS, 1280: number of W expansion words written during key setup.
- MIX_STEPS, 1024: number of initialisation mixing steps.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- init  in  1  start key/IV setup; level, sampled only when accepted.
- next  in  1  request next keystream word.
- ready  out  1  controller idle and able to accept a command.
- keyed  out  1  setup completed since last reset/init.
- s_valid  out  1  datapath s register holds a fresh word.
- exp_we  out  1  write W[exp_idx] (and P/Q load) this cycle.
- exp_idx  out  11  expansion word index, 0..EXP_WORDS-1.
- rd_en  out  1  step read phase: datapath registers table operands addressed by step.
- update_state  out  1  step write phase: write new P or Q entry.
- update_s  out  1  step write phase: load s register.
- init_mode  out  1  write phase uses init mixing (output fed back into table).
- step  out  10  step counter i; step[9] selects Q (1) or P (0); step[8:0] is j.

## Operation
States: IDLE, EXPAND, MIX_RD, MIX_WR, READY, GEN_RD, GEN_WR.
- IDLE: ready=1, keyed=0. init → EXPAND with exp_idx=0 and step=0. next is ignored.
- EXPAND: exp_we=1 every cycle; exp_idx increments. After exp_idx=EXP_WORDS-1 → MIX_RD with step=0.
- MIX_RD: rd_en=1 → MIX_WR.
- MIX_WR: update_state=1, init_mode=1, update_s=0.
  - step increments.
  - After step=MIX_STEPS-1 (step wraps to 0): → READY, keyed=1.
  - Otherwise → MIX_RD.
- READY: ready=1.
  - init → EXPAND (rekey).
  - Else next → GEN_RD.
  - init and next together: init wins.
- GEN_RD: rd_en=1 → GEN_WR.
- GEN_WR: update_state=1, update_s=1, init_mode=0; step increments mod 1024. Next state → READY (see Configuration).
- s_valid: pulses high for exactly one cycle, the cycle after each GEN_WR.
- init or next arriving outside IDLE/READY: ignored, not queued.
- Arithmetic:
  - step is a 10-bit wrap-around counter; 1023+1=0 with no flag. P/Q alternation follows step[9].
  - exp_idx saturates at EXP_WORDS-1 until it reloads.
- Strobe exclusivity: exp_we, rd_en and update_state are mutually exclusive in every cycle.

## Timing
- Reset: all outputs 0 except ready=1. State IDLE; step=0, exp_idx=0, keyed=0.
- reset_n low mid-operation (any state) returns to IDLE on that edge. No strobe is asserted in the following cycle.
- init sampled at edge T:
  - EXPAND occupies cycles T+1..T+1280.
  - MIX occupies T+1281..T+3328 (2 cycles per step).
  - ready=1 and keyed=1 from T+3329.
  - ready=0 from T+1.
- next sampled at edge T in READY:
  - rd_en at T+1.
  - update_s at T+2.
  - s_valid=1 during T+3 only.
  - ready=0 at T+1..T+2, high again at T+3.
- Keystream throughput: one word per 3 cycles (single mode).

## Configuration
- HC_CTRL_STREAM_EN defined: in GEN_WR, if next is still high, go directly to GEN_RD instead of READY.
  - Throughput becomes one word per 2 cycles.
  - s_valid pulses on every other cycle.
  - ready stays 0 while streaming.
  - init is not honoured until READY is reached.
- HC_CTRL_STREAM_EN undefined: GEN_WR always returns to READY. A held next produces one word per 3 cycles.

## Test plan
- Reset, then next=1 for 10 cycles without init → no rd_en/update_s, ready=1, keyed=0, step=0.
- init pulse at cycle 0:
  - exp_we high exactly 1280 cycles with exp_idx 0..1279.
  - 1024 rd_en and 1024 update_state pulses, all with init_mode=1.
  - ready and keyed rise at cycle 3329.
- After setup, three single next pulses:
  - s_valid at 3, 6, 9 cycles after each request edge.
  - step reads 1, 2, 3 after each word.
- 1024 keystream words:
  - step[9]=0 for words 0..511, 1 for 512..1023.
  - step wraps to 0 after word 1023.
- reset_n low during MIX (step=300) → next cycle ready=1, keyed=0, step=0, all strobes 0. init and next asserted simultaneously in READY → EXPAND entered, no s_valid.
- With HC_CTRL_STREAM_EN, hold next for 20 cycles → s_valid toggles every 2 cycles, 10 words, ready=0 throughout.
